// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: phase inputs and clear in, decoded
// position, step/err pulses and held left/right levels out.
interface quad_decoder_if #(
  parameter int CNT_W = 8
);
  logic             quad_a;
  logic             quad_b;
  logic             clear;
  logic [CNT_W-1:0] position;
  logic             step;
  logic             dir;
  logic             err;
  logic             left;
  logic             right;

  modport master (
    output quad_a, quad_b, clear,
    input  position, step, dir, err, left, right
  );

  modport slave (
    input  quad_a, quad_b, clear,
    output position, step, dir, err, left, right
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature spinner/wheel decoder: sync + glitch filter, wrapping
// position count, step/err pulses and held left/right levels.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_LEN    = 22500
) (
  input logic           CLK,
  input logic           Reset_n,
  quad_decoder_if.slave bus
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int HW = $clog2(HOLD_LEN + 1);
  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FILT_TOP  = FW'(FILT_LEN - 1);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_LEN);
  localparam logic [PW-1:0] PRIME_TOP = PW'(SYNC_STAGES);

  logic [1:0] raw;
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] sync_w;

  assign raw    = {bus.quad_a, bus.quad_b};
  assign sync_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Init holds until the synchroniser is primed, then loads
  // the filter and decode history with the live input level.
  logic          init_q, init_d;
  logic [PW-1:0] prime_q, prime_d;
  logic          load;

  assign load = init_q && (prime_q == PRIME_TOP);

  always_comb begin
    init_d  = init_q;
    prime_d = prime_q;
    if (load) begin
      init_d = 1'b0;
    end else if (init_q) begin
      prime_d = prime_q + PW'(1);
    end
  end

  logic [1:0]         filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        filt_d[k] = sync_w[k];
      end else if (!init_q && sync_w[k] != filt_q[k]) begin
        if (fcnt_q[k] == FILT_TOP) begin
          filt_d[k] = sync_w[k];
        end else begin
          fcnt_d[k] = fcnt_q[k] + FW'(1);
        end
      end
    end
  end

  logic [1:0] s_now_q, s_now_d;
  logic [1:0] s_prev_q, s_prev_d;
  logic [1:0] delta;
  logic       fwd, rev, bad;

  assign s_now_d  = load ? sync_w : filt_q;
  assign s_prev_d = load ? sync_w : s_now_q;

  // Gray {a,b} to ring index 0..3; forward is +1 mod 4.
  function automatic logic [1:0] ring_idx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  assign delta = ring_idx(s_now_q) - ring_idx(s_prev_q);
  assign fwd   = !init_q && (delta == 2'd1);
  assign rev   = !init_q && (delta == 2'd3);
  assign bad   = !init_q && (delta == 2'd2);

  logic [CNT_W-1:0] pos_q, pos_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             left_q, left_d;
  logic             right_q, right_d;

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = 1'b0;
    hold_d = (hold_q != '0) ? hold_q - HW'(1) : '0;
    unique case (1'b1)
      fwd: begin
        step_d = 1'b1;
        dir_d  = 1'b1;
        pos_d  = pos_q + CNT_W'(1);
        hold_d = HOLD_TOP;
      end
      rev: begin
        step_d = 1'b1;
        dir_d  = 1'b0;
        pos_d  = pos_q - CNT_W'(1);
        hold_d = HOLD_TOP;
      end
      bad: begin
        err_d = 1'b1;
      end
      default: begin
      end
    endcase
    if (bus.clear) begin
      pos_d = '0;
    end
    left_d  = (hold_d != '0) && !dir_d;
    right_d = (hold_d != '0) && dir_d;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      init_q   <= 1'b1;
      prime_q  <= '0;
      filt_q   <= '0;
      fcnt_q   <= '0;
      s_now_q  <= '0;
      s_prev_q <= '0;
      pos_q    <= '0;
      hold_q   <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      init_q   <= init_d;
      prime_q  <= prime_d;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      s_now_q  <= s_now_d;
      s_prev_q <= s_prev_d;
      pos_q    <= pos_d;
      hold_q   <= hold_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  assign bus.position = pos_q;
  assign bus.step     = step_q;
  assign bus.dir      = dir_q;
  assign bus.err      = err_q;
  assign bus.left     = left_q;
  assign bus.right    = right_q;
endmodule
